uart_avmm_csr_mc: RTL and testbench

// - Multi-channel Avalon-MM CSR front end for N_CH UART cores; one 8-word register window per channel.
// - Adds IRQ status/enable, reset baud values, RX-read timeout, TX-overflow detect.
// - Sits between the system interconnect and per-channel UART TX/RX FIFOs.

---
 rtl/uart_csr_pkg.sv | 33 +++
 rtl/uart_avmm_csr_mc_if.sv | 17 +
 rtl/uart_csr_chan.sv | 118 +++++++++++
 rtl/uart_avmm_csr_mc.sv | 171 +++++++++++++++++
 tb/tb_uart_avmm_csr_mc.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_csr_pkg.sv
// Shared constants, FSM encoding and byte-merge helper for the multi-channel UART CSR block.
package uart_csr_pkg;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_BAUD     = 3'd1;
  localparam logic [2:0] OFS_TX_FILL  = 3'd2;
  localparam logic [2:0] OFS_RX_FILL  = 3'd3;
  localparam logic [2:0] OFS_TX_DATA  = 3'd4;
  localparam logic [2:0] OFS_RX_DATA  = 3'd5;
  localparam logic [2:0] OFS_IRQ_STAT = 3'd6;
  localparam logic [2:0] OFS_IRQ_EN   = 3'd7;

  localparam int IRQ_RX_NE   = 0;
  localparam int IRQ_TX_E    = 1;
  localparam int IRQ_TX_OVF  = 2;
  localparam int IRQ_RX_PERR = 3;

  localparam logic [31:0] RX_EMPTY_FLAG = 32'h8000_0000;
  localparam logic [31:0] RX_TMO_FLAG   = 32'h4000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RX_WAIT
  } csr_state_e;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic [1:0]  be);
    return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

endpackage

// File: rtl/uart_avmm_csr_mc_if.sv
// Avalon-MM slave bus bundle for the UART CSR window.
interface uart_avmm_csr_mc_if #(
  parameter int AW = 4
);
  logic [AW-1:0] address;
  logic          write;
  logic          read;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic          waitrequest;
  logic [31:0]   readdata;

  modport master (output address, write, read, writedata, byteenable,
                  input  waitrequest, readdata);
  modport slave  (input  address, write, read, writedata, byteenable,
                  output waitrequest, readdata);
endinterface

// File: rtl/uart_csr_chan.sv
// One UART channel's register file: CTRL/BAUD, TX push, IRQ regs and read mux.
// IRQ_STAT/IRQ_EN exist only when UART_CSR_IRQ_EN is defined.
module uart_csr_chan
  import uart_csr_pkg::*;
#(
  parameter int          FILL_W         = 16,
  parameter logic [15:0] BAUD_FREQ_RST  = 16'd1,
  parameter logic [15:0] BAUD_LIMIT_RST = 16'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [2:0]        ofs_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  input  logic              tx_empty_i,
  input  logic              tx_full_i,
  input  logic              rx_empty_i,
  input  logic              rx_full_i,
  input  logic [FILL_W-1:0] tx_fill_i,
  input  logic [FILL_W-1:0] rx_fill_i,
  input  logic              perr_set_i,
  output logic              cr_pbit_o,
  output logic              cr_ptype_o,
  output logic [1:0]        cr_sbit_o,
  output logic [15:0]       baud_freq_o,
  output logic [15:0]       baud_limit_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_valid_o,
  output logic [31:0]       rdata_o,
  output logic              irq_o
);

  logic [3:0]  ctrl_q;
  logic [15:0] freq_q, limit_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic [3:0]  stat;
  logic [3:0]  irq_en;
  logic        wr_tx, tx_ovf_set;

  assign wr_tx      = wr_en_i && (ofs_i == OFS_TX_DATA) && be_i[0];
  assign tx_ovf_set = wr_tx && tx_full_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      freq_q     <= BAUD_FREQ_RST;
      limit_q    <= BAUD_LIMIT_RST;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= wr_tx && !tx_full_i;
      if (wr_tx && !tx_full_i) tx_byte_q <= wdata_i[7:0];
      if (wr_en_i && (ofs_i == OFS_CTRL) && be_i[1]) ctrl_q <= wdata_i[11:8];
      if (wr_en_i && (ofs_i == OFS_BAUD)) begin
        freq_q  <= merge_bytes(freq_q,  wdata_i[31:16], be_i[3:2]);
        limit_q <= merge_bytes(limit_q, wdata_i[15:0],  be_i[1:0]);
      end
    end
  end

`ifdef UART_CSR_IRQ_EN
  logic       ovf_q, perr_q;
  logic [3:0] en_q;
  logic       wr_stat;

  assign wr_stat = wr_en_i && (ofs_i == OFS_IRQ_STAT) && be_i[0];

  // Sticky bits: a same-cycle set overrides the W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      en_q   <= '0;
    end else begin
      ovf_q  <= (ovf_q  && !(wr_stat && wdata_i[IRQ_TX_OVF]))  || tx_ovf_set;
      perr_q <= (perr_q && !(wr_stat && wdata_i[IRQ_RX_PERR])) || perr_set_i;
      if (wr_en_i && (ofs_i == OFS_IRQ_EN) && be_i[0]) en_q <= wdata_i[3:0];
    end
  end

  assign stat[IRQ_RX_NE]   = !rx_empty_i;
  assign stat[IRQ_TX_E]    = tx_empty_i;
  assign stat[IRQ_TX_OVF]  = ovf_q;
  assign stat[IRQ_RX_PERR] = perr_q;
  assign irq_en            = en_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = perr_set_i | tx_ovf_set;
  assign stat          = '0;
  assign irq_en        = '0;
`endif

  assign irq_o = |(stat & irq_en);

  always_comb begin
    rdata_o = '0;
    case (ofs_i)
      OFS_CTRL:     rdata_o = {20'h0, ctrl_q, 4'h0, tx_full_i, tx_empty_i, rx_full_i, rx_empty_i};
      OFS_BAUD:     rdata_o = {freq_q, limit_q};
      OFS_TX_FILL:  rdata_o = 32'(tx_fill_i);
      OFS_RX_FILL:  rdata_o = 32'(rx_fill_i);
      OFS_IRQ_STAT: rdata_o = {28'h0, stat};
      OFS_IRQ_EN:   rdata_o = {28'h0, irq_en};
      default:      rdata_o = '0;
    endcase
  end

  assign cr_pbit_o    = ctrl_q[0];
  assign cr_ptype_o   = ctrl_q[1];
  assign cr_sbit_o    = ctrl_q[3:2];
  assign baud_freq_o  = freq_q;
  assign baud_limit_o = limit_q;
  assign tx_byte_o    = tx_byte_q;
  assign tx_valid_o   = tx_valid_q;

endmodule

// File: rtl/uart_avmm_csr_mc.sv
// Avalon-MM CSR front end for N_CH UART channels: access FSM, RX pop/timeout, decode, irq_o.
// Optional feature macro: UART_CSR_IRQ_EN (IRQ_STAT/IRQ_EN registers and live irq_o).
module uart_avmm_csr_mc
  import uart_csr_pkg::*;
#(
  parameter int          N_CH           = 2,
  parameter int          FILL_W         = 16,
  parameter logic [15:0] BAUD_FREQ_RST  = 16'd1,
  parameter logic [15:0] BAUD_LIMIT_RST = 16'd1,
  parameter int          RX_TMO         = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  uart_avmm_csr_mc_if.slave        avmms,
  output logic [N_CH-1:0]          cr_pbit,
  output logic [N_CH-1:0]          cr_ptype,
  output logic [2*N_CH-1:0]        cr_sbit,
  output logic [16*N_CH-1:0]       cr_baud_freq,
  output logic [16*N_CH-1:0]       cr_baud_limit,
  input  logic [N_CH-1:0]          fifo_tx_empty,
  input  logic [N_CH-1:0]          fifo_tx_full,
  input  logic [N_CH-1:0]          fifo_rx_empty,
  input  logic [N_CH-1:0]          fifo_rx_full,
  input  logic [FILL_W*N_CH-1:0]   fifo_tx_fill,
  input  logic [FILL_W*N_CH-1:0]   fifo_rx_fill,
  output logic [8*N_CH-1:0]        tx_byte,
  output logic [N_CH-1:0]          tx_valid,
  output logic [N_CH-1:0]          rx_read,
  input  logic [9*N_CH-1:0]        rx_readdata,
  input  logic [N_CH-1:0]          rx_readdatavalid,
  output logic                     irq_o
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW    = CH_W + 3;
  localparam int TMO_W = $clog2(RX_TMO + 1);

  csr_state_e        state_q, state_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [N_CH-1:0]   rx_read_q, rx_read_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic [CH_W-1:0]   req_ch;
  logic [2:0]        req_ofs;
  logic              ch_ok, wr_en;
  logic [N_CH-1:0]   chan_wr, perr_set, chan_irq;
  logic [31:0]       chan_rdata [N_CH];
  logic [8:0]        rx_data    [N_CH];

  assign req_ch  = avmms.address[AW-1:3];
  assign req_ofs = avmms.address[2:0];
  assign ch_ok   = ({1'b0, req_ch} < (CH_W+1)'(N_CH));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign rx_data[i]  = rx_readdata[9*i +: 9];
    assign chan_wr[i]  = wr_en && ch_ok && (req_ch == CH_W'(i));
    assign perr_set[i] = (state_q == ST_RX_WAIT) && (ch_q == CH_W'(i)) &&
                         rx_readdatavalid[i] && rx_data[i][8];

    uart_csr_chan #(
      .FILL_W        (FILL_W),
      .BAUD_FREQ_RST (BAUD_FREQ_RST),
      .BAUD_LIMIT_RST(BAUD_LIMIT_RST)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en_i     (chan_wr[i]),
      .ofs_i       (req_ofs),
      .wdata_i     (avmms.writedata),
      .be_i        (avmms.byteenable),
      .tx_empty_i  (fifo_tx_empty[i]),
      .tx_full_i   (fifo_tx_full[i]),
      .rx_empty_i  (fifo_rx_empty[i]),
      .rx_full_i   (fifo_rx_full[i]),
      .tx_fill_i   (fifo_tx_fill[FILL_W*i +: FILL_W]),
      .rx_fill_i   (fifo_rx_fill[FILL_W*i +: FILL_W]),
      .perr_set_i  (perr_set[i]),
      .cr_pbit_o   (cr_pbit[i]),
      .cr_ptype_o  (cr_ptype[i]),
      .cr_sbit_o   (cr_sbit[2*i +: 2]),
      .baud_freq_o (cr_baud_freq[16*i +: 16]),
      .baud_limit_o(cr_baud_limit[16*i +: 16]),
      .tx_byte_o   (tx_byte[8*i +: 8]),
      .tx_valid_o  (tx_valid[i]),
      .rdata_o     (chan_rdata[i]),
      .irq_o       (chan_irq[i])
    );
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    rx_read_d  = '0;
    tmo_d      = tmo_q;
    ch_d       = ch_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avmms.write) begin
          wr_en   = 1'b1;
          state_d = ST_ACK;
        end else if (avmms.read) begin
          ch_d = req_ch;
          if (ch_ok && (req_ofs == OFS_RX_DATA)) begin
            if (fifo_rx_empty[req_ch]) begin
              readdata_d = RX_EMPTY_FLAG;
              state_d    = ST_ACK;
            end else begin
              rx_read_d[req_ch] = 1'b1;
              tmo_d             = '0;
              state_d           = ST_RX_WAIT;
            end
          end else begin
            readdata_d = ch_ok ? chan_rdata[req_ch] : 32'h0;
            state_d    = ST_ACK;
          end
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_RX_WAIT: begin
        if (rx_readdatavalid[ch_q]) begin
          readdata_d = {23'h0, rx_data[ch_q]};
          state_d    = ST_ACK;
        end else if (tmo_q == TMO_W'(RX_TMO - 1)) begin
          readdata_d = RX_TMO_FLAG;
          state_d    = ST_ACK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      readdata_q <= '0;
      rx_read_q  <= '0;
      tmo_q      <= '0;
      ch_q       <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      rx_read_q  <= rx_read_d;
      tmo_q      <= tmo_d;
      ch_q       <= ch_d;
    end
  end

  assign avmms.waitrequest = (state_q != ST_ACK);
  assign avmms.readdata    = readdata_q;
  assign rx_read           = rx_read_q;

`ifdef UART_CSR_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |chan_irq;
  end
  assign irq_o = irq_q;
`else
  logic unused_irq;
  assign unused_irq = |chan_irq;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_avmm_csr_mc.sv
// Self-checking bench for uart_avmm_csr_mc: directed cases then randomized accesses vs. a register model.
module tb_uart_avmm_csr_mc;

  localparam int          N_CH   = 3;
  localparam int          FILL_W = 16;
  localparam int          RX_TMO = 15;
  localparam int          AW     = 5;
  localparam logic [15:0] FRST   = 16'h1234;
  localparam logic [15:0] LRST   = 16'h0056;
`ifdef UART_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_avmm_csr_mc_if #(.AW(AW)) bus ();

  logic [N_CH-1:0]        cr_pbit, cr_ptype, tx_valid, rx_read;
  logic [2*N_CH-1:0]      cr_sbit;
  logic [16*N_CH-1:0]     cr_baud_freq, cr_baud_limit;
  logic [N_CH-1:0]        fifo_tx_empty, fifo_tx_full, fifo_rx_empty, fifo_rx_full, rx_readdatavalid;
  logic [FILL_W*N_CH-1:0] fifo_tx_fill, fifo_rx_fill;
  logic [8*N_CH-1:0]      tx_byte;
  logic [9*N_CH-1:0]      rx_readdata;
  logic                   irq_o;

  uart_avmm_csr_mc #(
    .N_CH(N_CH), .FILL_W(FILL_W), .BAUD_FREQ_RST(FRST), .BAUD_LIMIT_RST(LRST), .RX_TMO(RX_TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avmms(bus),
    .cr_pbit(cr_pbit), .cr_ptype(cr_ptype), .cr_sbit(cr_sbit),
    .cr_baud_freq(cr_baud_freq), .cr_baud_limit(cr_baud_limit),
    .fifo_tx_empty(fifo_tx_empty), .fifo_tx_full(fifo_tx_full),
    .fifo_rx_empty(fifo_rx_empty), .fifo_rx_full(fifo_rx_full),
    .fifo_tx_fill(fifo_tx_fill), .fifo_rx_fill(fifo_rx_fill),
    .tx_byte(tx_byte), .tx_valid(tx_valid),
    .rx_read(rx_read), .rx_readdata(rx_readdata), .rx_readdatavalid(rx_readdatavalid),
    .irq_o(irq_o)
  );

  int errs = 0, checks = 0;
  int exp_push = 0, seen_push = 0;

  logic [3:0]  m_ctrl  [N_CH];
  logic [15:0] m_freq  [N_CH];
  logic [15:0] m_limit [N_CH];
  logic        m_ovf   [N_CH];
  logic        m_perr  [N_CH];
  logic [3:0]  m_en    [N_CH];

  always @(negedge clk) seen_push += $countones(tx_valid);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_ctrl[i] = '0; m_freq[i] = FRST; m_limit[i] = LRST;
      m_ovf[i] = 1'b0; m_perr[i] = 1'b0; m_en[i] = '0;
    end
  endtask

  function automatic logic [3:0] m_stat(input int ch);
    return {m_perr[ch], m_ovf[ch], fifo_tx_empty[ch], !fifo_rx_empty[ch]};
  endfunction

  function automatic logic [31:0] exp_read(input int ch, input int ofs);
    if (ch >= N_CH) return 32'h0;
    case (ofs)
      0: return {20'h0, m_ctrl[ch], 4'h0, fifo_tx_full[ch], fifo_tx_empty[ch], fifo_rx_full[ch], fifo_rx_empty[ch]};
      1: return {m_freq[ch], m_limit[ch]};
      2: return {16'h0, fifo_tx_fill[ch*FILL_W +: FILL_W]};
      3: return {16'h0, fifo_rx_fill[ch*FILL_W +: FILL_W]};
      6: return IRQ_ON ? {28'h0, m_stat(ch)} : 32'h0;
      7: return IRQ_ON ? {28'h0, m_en[ch]} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    logic r = 1'b0;
    for (int i = 0; i < N_CH; i++) r |= |(m_stat(i) & m_en[i]);
    return IRQ_ON ? r : 1'b0;
  endfunction

  // Returns 1 when the write should push a byte to the TX FIFO.
  function automatic bit model_write(input int ch, input int ofs, input logic [31:0] wd, input logic [3:0] be);
    if (ch >= N_CH) return 1'b0;
    case (ofs)
      0: if (be[1]) m_ctrl[ch] = wd[11:8];
      1: begin
        if (be[3]) m_freq[ch][15:8]  = wd[31:24];
        if (be[2]) m_freq[ch][7:0]   = wd[23:16];
        if (be[1]) m_limit[ch][15:8] = wd[15:8];
        if (be[0]) m_limit[ch][7:0]  = wd[7:0];
      end
      4: if (be[0]) begin
        if (fifo_tx_full[ch]) m_ovf[ch] = 1'b1;
        else return 1'b1;
      end
      6: if (be[0]) begin
        if (wd[2]) m_ovf[ch]  = 1'b0;
        if (wd[3]) m_perr[ch] = 1'b0;
      end
      7: if (be[0]) m_en[ch] = wd[3:0];
      default: ;
    endcase
    return 1'b0;
  endfunction

  task automatic check_outputs();
    logic [3*N_CH-1:0]  e_ctrl;
    logic [32*N_CH-1:0] e_baud;
    for (int i = 0; i < N_CH; i++) begin
      e_ctrl[3*i +: 3]   = {m_ctrl[i][1], m_ctrl[i][0], 1'b0} | 3'(0);
      e_baud[32*i +: 32] = {m_freq[i], m_limit[i]};
    end
    for (int i = 0; i < N_CH; i++) begin
      check("cr_pbit",  cr_pbit[i],        m_ctrl[i][0]);
      check("cr_ptype", cr_ptype[i],       m_ctrl[i][1]);
      check("cr_sbit",  cr_sbit[2*i +: 2], m_ctrl[i][3:2]);
      check("cr_baud",  {cr_baud_freq[16*i +: 16], cr_baud_limit[16*i +: 16]}, e_baud[32*i +: 32]);
    end
  endtask

  // One bus access; plays the RX FIFO when the DUT pops (rsp_dly==0: never answers).
  task automatic access(input bit wr, input bit both, input int ch, input int ofs,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int rsp_dly, input logic [8:0] rsp_d,
                        output logic [31:0] rd, output int cyc, output int nrx,
                        output logic [N_CH-1:0] txv, output logic [8*N_CH-1:0] txb);
    int  cd;
    bit  done;
    @(negedge clk);
    bus.address    = AW'(ch * 8 + ofs);
    bus.write      = wr;
    bus.read       = !wr || both;
    bus.writedata  = wd;
    bus.byteenable = be;
    cyc = 0; nrx = 0; cd = -1; done = 1'b0; rd = '0; txv = '0; txb = '0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      rx_readdatavalid = '0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rx_readdatavalid[ch]   = 1'b1;
          rx_readdata[ch*9 +: 9] = rsp_d;
        end
      end
      if (rx_read != '0) begin
        nrx += $countones(rx_read);
        if (rsp_dly > 0) cd = rsp_dly;
      end
      if (!bus.waitrequest) begin
        done = 1'b1;
        rd   = bus.readdata;
        txv  = tx_valid;
        txb  = tx_byte;
      end
    end
    if (!done) check("ack_timeout", 0, 1);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    rx_readdatavalid = '0;
  endtask

  task automatic do_op(input int ch, input int ofs, input bit wr, input logic [31:0] wd,
                       input logic [3:0] be, input int rsp_dly, input logic [8:0] rsp_d,
                       input bit both = 1'b0);
    logic [31:0]       rd, exp;
    int                cyc, nrx;
    logic [N_CH-1:0]   txv;
    logic [8*N_CH-1:0] txb;
    bit                push, rx_pop;
    rx_pop = !wr && (ofs == 5) && (ch < N_CH);
    exp    = exp_read(ch, ofs);
    if (rx_pop) begin
      if (fifo_rx_empty[ch]) exp = 32'h8000_0000;
      else if (rsp_dly > 0)  exp = {23'h0, rsp_d};
      else                   exp = 32'h4000_0000;
    end
    access(wr, both, ch, ofs, wd, be, rsp_dly, rsp_d, rd, cyc, nrx, txv, txb);
    if (wr) begin
      push = model_write(ch, ofs, wd, be);
      check("wr_latency", cyc, 1);
      check("wr_no_pop", nrx, 0);
      if (ofs == 4) begin
        check("tx_valid", txv, push ? (N_CH'(1) << ch) : '0);
        if (push) check("tx_byte", txb[ch*8 +: 8], wd[7:0]);
      end
      if (push) exp_push++;
    end else if (rx_pop) begin
      check("rx_data", rd, exp);
      check("rx_pops", nrx, fifo_rx_empty[ch] ? 0 : 1);
      if (fifo_rx_empty[ch]) check("rx_empty_lat", cyc, 1);
      else if (rsp_dly == 0) check("rx_tmo_lat", (cyc >= RX_TMO && cyc <= RX_TMO + 2), 1);
      if (!fifo_rx_empty[ch] && rsp_dly > 0 && rsp_d[8]) m_perr[ch] = 1'b1;
    end else begin
      check("rd_data", rd, exp);
      check("rd_latency", cyc, 1);
      check("rd_no_pop", nrx, 0);
    end
    @(posedge clk); #1;
    check("wait_hi", bus.waitrequest, 1);
    @(negedge clk); @(negedge clk);
    check("irq_o", irq_o, model_irq());
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    reset_n = 1'b0;
    bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0; bus.byteenable = '0;
    fifo_tx_empty = '1; fifo_tx_full = '0; fifo_rx_empty = '1; fifo_rx_full = '0;
    fifo_tx_fill = '0; fifo_rx_fill = '0; rx_readdata = '0; rx_readdatavalid = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_waitreq",  bus.waitrequest, 1);
    check("rst_readdata", bus.readdata, 0);
    check("rst_irq",      irq_o, 0);
    check("rst_txvalid",  tx_valid, 0);
    check("rst_txbyte",   tx_byte, 0);
    check("rst_rxread",   rx_read, 0);
    check_outputs();
    reset_n = 1'b1;

    do_op(1, 1, 1'b0, 0, 4'h0, 0, 0);
    do_op(0, 0, 1'b1, 32'h0000_0B00, 4'b0010, 0, 0);
    check("ctrl_sbit0",  cr_sbit[1:0], 2);
    check("ctrl_ptype0", cr_ptype[0], 1);
    check("ctrl_pbit0",  cr_pbit[0], 1);
    check_outputs();

    do_op(1, 4, 1'b1, 32'h0000_00A5, 4'h1, 0, 0);
    fifo_tx_full[1] = 1'b1;
    do_op(1, 4, 1'b1, 32'h0000_003C, 4'h1, 0, 0);
    do_op(1, 6, 1'b0, 0, 4'h0, 0, 0);
    fifo_tx_full[1] = 1'b0;

    fifo_rx_empty[0] = 1'b0;
    do_op(0, 5, 1'b0, 0, 4'h0, 3, 9'h155);
    do_op(0, 6, 1'b0, 0, 4'h0, 0, 0);
    do_op(0, 7, 1'b1, 32'h0000_000C, 4'h1, 0, 0);
    do_op(0, 5, 1'b0, 0, 4'h0, 0, 0);
    fifo_rx_empty[0] = 1'b1;
    do_op(0, 5, 1'b0, 0, 4'h0, 2, 9'h011);
    do_op(0, 6, 1'b1, 32'h0000_000C, 4'h1, 0, 0);
    do_op(0, 6, 1'b0, 0, 4'h0, 0, 0);

    do_op(3, 0, 1'b0, 0, 4'h0, 0, 0);
    do_op(3, 1, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_op(3, 5, 1'b0, 0, 4'h0, 2, 9'h1FF);
    do_op(2, 1, 1'b1, 32'hAABB_CCDD, 4'b1001, 0, 0);
    do_op(2, 0, 1'b1, 32'h0000_0700, 4'h2, 0, 0, 1'b1);
    check_outputs();

    fifo_rx_empty[0] = 1'b0;
    @(negedge clk);
    bus.address = AW'(5); bus.read = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rxwait_waitreq", bus.waitrequest, 1);
    check("rxwait_popped",  rx_read, 0);
    reset_n = 1'b0;
    #1;
    bus.read = 1'b0;
    model_reset();
    check("midrst_waitreq",  bus.waitrequest, 1);
    check("midrst_readdata", bus.readdata, 0);
    check("midrst_irq",      irq_o, 0);
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1, 1, 1'b0, 0, 4'h0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      rnd = $urandom;
      fifo_tx_empty = N_CH'(rnd);
      fifo_tx_full  = N_CH'(rnd >> 4);
      fifo_rx_empty = N_CH'(rnd >> 8);
      fifo_rx_full  = N_CH'(rnd >> 12);
      for (int i = 0; i < N_CH; i++) begin
        fifo_tx_fill[i*FILL_W +: FILL_W] = FILL_W'($urandom);
        fifo_rx_fill[i*FILL_W +: FILL_W] = FILL_W'($urandom);
      end
      do_op($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom,
            4'($urandom), $urandom_range(0, 4), 9'($urandom));
      if (n % 25 == 0) check_outputs();
    end
    check_outputs();
    check("tx_push_count", seen_push, exp_push);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
